// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a req/gnt/rvalid
// handshake and buffers returned {pc, instr} pairs in order for the IF/ID register.
module fetch_unit #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] PC_out,
    output logic [31:0]         instruction_out,
    output logic                valid_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [PC_WIDTH-1:0] pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       drop;
    logic [CW-1:0]       count;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       tag_rd;
    logic [AW-1:0]       tag_wr;

    logic [PC_WIDTH-1:0] fifo_pc    [DEPTH];
    logic [31:0]         fifo_instr [DEPTH];
    logic [PC_WIDTH-1:0] tag_pc     [DEPTH];

    logic [CW:0] occupancy;
    logic        grant;
    logic        resp;
    logic        push;
    logic        pop;

    // In-flight fetches (including ones still to be dropped) share the cap with buffered words.
    assign occupancy = {1'b0, outstanding} + {1'b0, count};
    assign imem_req  = !rst && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc;

    assign grant = imem_req && imem_gnt;
    assign resp  = imem_rvalid && (outstanding != '0);
    assign push  = resp && (drop == '0);
    assign pop   = valid_out && !stall && !flush;

    assign valid_out       = (count != '0);
    assign PC_out          = valid_out ? fifo_pc[rd_ptr] : '0;
    assign instruction_out = valid_out ? fifo_instr[rd_ptr] : NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
                tag_pc[i]     <= '0;
            end
        end else if (flush) begin
            // Everything still in flight after this edge, including a same-cycle grant, is stale.
            pc          <= redirect_pc;
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            drop        <= outstanding + CW'(grant) - CW'(resp);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            count       <= count + CW'(push) - CW'(pop);
            if (grant) begin
                pc             <= pc + PC_WIDTH'(4);
                tag_pc[tag_wr] <= pc;
                tag_wr         <= tag_wr + AW'(1);
            end
            if (resp && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (push) begin
                fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= wr_ptr + AW'(1);
                tag_rd             <= tag_rd + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency/grant
// and a queue-based reference of the expected fetch stream.
module tb_fetch_unit;
    localparam int          PC_WIDTH = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [63:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC_out(PC_out), .instruction_out(instruction_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        longint      due;
        int          epoch;
    } pend_t;

    // Memory and reference state: pend holds granted fetches, live_q the words IF/ID should see.
    pend_t       pend[$];
    logic [63:0] live_q[$];
    pend_t       head;
    pend_t       entry;
    int          epoch = 0;
    longint      cyc = 0;
    longint      last_due = 0;
    logic [63:0] exp_fetch_pc = RESET_PC;
    logic        m_req;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        m_req = !rst && ((pend.size() + live_q.size()) < DEPTH);
        if (rst) begin
            pend.delete();
            live_q.delete();
            epoch++;
            exp_fetch_pc = RESET_PC;
            last_due = cyc;
        end else begin
            if (live_q.size() != 0 && !stall && !flush) begin
                void'(live_q.pop_front());
            end
            if (imem_rvalid && pend.size() != 0) begin
                head = pend.pop_front();
                if (head.epoch == epoch && !flush) live_q.push_back(head.addr);
            end
            if (m_req && imem_gnt) begin
                entry.addr  = exp_fetch_pc;
                entry.due   = cyc + longint'($urandom_range(lat_max, lat_min));
                if (entry.due <= last_due) entry.due = last_due + 1;
                last_due    = entry.due;
                entry.epoch = epoch;
                pend.push_back(entry);
            end
            if (flush) begin
                epoch++;
                live_q.delete();
                exp_fetch_pc = redirect_pc;
            end else if (m_req && imem_gnt) begin
                exp_fetch_pc = exp_fetch_pc + 64'd4;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_async: got %0b expected 0", imem_req); end
        @(negedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b expected 0", imem_req); end
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid_out); end
        checks++;
        if (PC_out !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", PC_out); end
        checks++;
        if (instruction_out !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", instruction_out, NOP); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %0b expected 1", imem_req); end
        checks++;
        if (imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL release_addr: got %h expected %h", imem_addr, RESET_PC); end
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL release_valid: got %0b expected 0", valid_out); end
    endtask

    task automatic test_stream();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL stream_early_valid: got %0b expected 0", valid_out); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (valid_out !== 1'b1 || PC_out !== RESET_PC + 64'(4 * k)) begin
                errors++;
                $display("[TB] FAIL stream_pc%0d: got valid=%0b pc=%h expected valid=1 pc=%h", k, valid_out, PC_out, RESET_PC + 64'(4 * k));
            end
            checks++;
            if (instruction_out !== word_of(RESET_PC + 64'(4 * k))) begin
                errors++;
                $display("[TB] FAIL stream_instr%0d: got %h expected %h", k, instruction_out, word_of(RESET_PC + 64'(4 * k)));
            end
        end
    endtask

    // Continues directly from test_stream: head is 0x100C on the next cycle.
    task automatic test_stall();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stall = 1'b1;
            #1;
            checks++;
            if (valid_out !== 1'b1 || PC_out !== RESET_PC + 64'd12) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got valid=%0b pc=%h expected valid=1 pc=%h", k, valid_out, PC_out, RESET_PC + 64'd12);
            end
        end
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_req: got %0b expected 0", imem_req); end
        @(negedge clk);
        stall = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (valid_out !== 1'b1 || PC_out !== RESET_PC + 64'(12 + 4 * k) ||
                instruction_out !== word_of(RESET_PC + 64'(12 + 4 * k))) begin
                errors++;
                $display("[TB] FAIL stall_resume%0d: got valid=%0b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                         k, valid_out, PC_out, instruction_out, RESET_PC + 64'(12 + 4 * k), word_of(RESET_PC + 64'(12 + 4 * k)));
            end
        end
    endtask

    task automatic test_flush_inflight();
        int n;
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        redirect_pc = 64'h2000;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n = 0;
        while (!valid_out && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (valid_out !== 1'b1 || PC_out !== 64'h2000 || instruction_out !== word_of(64'h2000)) begin
            errors++;
            $display("[TB] FAIL flush_inflight_first: got valid=%0b pc=%h instr=%h expected valid=1 pc=2000 instr=%h",
                     valid_out, PC_out, instruction_out, word_of(64'h2000));
        end
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!valid_out && n < 20);
        checks++;
        if (valid_out !== 1'b1 || PC_out !== 64'h2004) begin
            errors++;
            $display("[TB] FAIL flush_inflight_second: got valid=%0b pc=%h expected valid=1 pc=2004", valid_out, PC_out);
        end
    endtask

    task automatic test_flush_grant();
        int n;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        redirect_pc = 64'h2000;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 64'd12) begin
            errors++;
            $display("[TB] FAIL flush_grant_pre: got req=%0b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC + 64'd12);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
            errors++;
            $display("[TB] FAIL flush_grant_next_addr: got req=%0b addr=%h expected req=1 addr=2000", imem_req, imem_addr);
        end
        n = 0;
        while (!valid_out && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (valid_out !== 1'b1 || PC_out !== 64'h2000) begin
            errors++;
            $display("[TB] FAIL flush_grant_first: got valid=%0b pc=%h expected valid=1 pc=2000", valid_out, PC_out);
        end
    endtask

    task automatic test_random();
        logic [63:0] redir;
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 10000 && errors < 40; i++) begin
            @(negedge clk);
            stall = ($urandom_range(99) < 30);
            flush = ($urandom_range(99) < 3);
            redir = {$urandom, $urandom};
            if ($urandom_range(9) == 0) redir = 64'hFFFF_FFFF_FFFF_FFF0;
            redir[1:0] = 2'b00;
            redirect_pc = redir;
            #1;
            checks++;
            if (imem_req !== (pend.size() + live_q.size() < DEPTH)) begin
                errors++;
                $display("[TB] FAIL rand_req cycle %0d: got %0b expected %0b", i, imem_req, (pend.size() + live_q.size() < DEPTH));
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== exp_fetch_pc) begin
                    errors++;
                    $display("[TB] FAIL rand_addr cycle %0d: got %h expected %h", i, imem_addr, exp_fetch_pc);
                end
            end
            checks++;
            if (valid_out !== (live_q.size() != 0)) begin
                errors++;
                $display("[TB] FAIL rand_valid cycle %0d: got %0b expected %0b", i, valid_out, (live_q.size() != 0));
            end
            if (live_q.size() != 0) begin
                checks++;
                if (PC_out !== live_q[0] || instruction_out !== word_of(live_q[0])) begin
                    errors++;
                    $display("[TB] FAIL rand_head cycle %0d: got pc=%h instr=%h expected pc=%h instr=%h",
                             i, PC_out, instruction_out, live_q[0], word_of(live_q[0]));
                end
            end else begin
                checks++;
                if (instruction_out !== NOP) begin
                    errors++;
                    $display("[TB] FAIL rand_bubble cycle %0d: got %h expected %h", i, instruction_out, NOP);
                end
            end
        end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 6; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_req_async: got %0b expected 0", imem_req); end
        @(negedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || instruction_out !== NOP || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got valid=%0b instr=%h req=%0b expected valid=0 instr=%h req=0",
                     valid_out, instruction_out, imem_req, NOP);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL mid_reset_restart: got req=%0b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b1 || PC_out !== RESET_PC || instruction_out !== word_of(RESET_PC)) begin
            errors++;
            $display("[TB] FAIL mid_reset_first: got valid=%0b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                     valid_out, PC_out, instruction_out, RESET_PC, word_of(RESET_PC));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_inflight();
        test_flush_grant();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
